canvas_write_ctrl: RTL and testbench
====================================

Name: canvas_write_ctrl

Overview:
- Owns the write port of the paint-canvas RAM: 2-bit colour code per pixel, write address {x[9:0], y[9:0]}.
- The display path keeps the read port; this block never drives it.
- Arbitrates between brush-stamp requests from the laser-spot tracker and a full-canvas clear, and sequences each as a stream of one-pixel-per-cycle writes.
- Sits between the spot tracker/user controls and the canvas RAM, beside the colour mapper.

Parameters:
- H_RES, 640, visible width; x range 0..H_RES-1.
- V_RES, 480, visible height; y range 0..V_RES-1.
- BRUSH_R, 2, brush half-width; square stamp of (2*BRUSH_R+1)^2 pixels.
- COLOR_W, 2, width of a canvas colour code.

Ports:
- CLK  in  1  system clock.
- Reset_n  in  1  synchronous active-low reset.
- paint_valid  in  1  stamp request valid.
- paint_ready  out  1  stamp request accepted when valid&ready.
- paint_x  in  10  brush centre x.
- paint_y  in  10  brush centre y.
- paint_color  in  COLOR_W  colour code; 0 = erase.
- clear_req  in  1  single-cycle request to clear the whole canvas to 0.
- wr_en  out  1  canvas RAM write enable.
- wr_addr  out  20  {x, y} write address.
- wr_data  out  COLOR_W  write data.
- busy  out  1  high in STAMP or CLEAR.
- clear_done  out  1  one-cycle pulse after the last clear write.

Behaviour:
- Single clock domain. Reset_n is sampled on the CLK edge, active-low and synchronous. Reset always wins, including mid-operation.
- Reset values: state=IDLE, clear_pend=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, clear_done=0, paint_ready=0 during reset.
- All outputs are registered except paint_ready, which is combinational: (state==IDLE) && !clear_pend && Reset_n.
- States:
  - IDLE: wait for work.
  - STAMP: scan the brush square.
  - CLEAR: sweep the full canvas.
- Transitions out of IDLE:
  - clear_pend=1 -> CLEAR. Clear has priority over a concurrent paint_valid, which stays stalled (ready low).
  - Else paint_valid&ready at edge T -> STAMP. Latch centre and colour. Offsets dx=dy=-BRUSH_R.
- STAMP:
  - One pixel per cycle. Raster order: dy outer, dx inner, each -BRUSH_R..+BRUSH_R.
  - First write is visible in cycle T+1.
  - Coordinates use 11-bit signed arithmetic: px=cx+dx, py=cy+dy.
  - In range (0<=px<H_RES, 0<=py<V_RES): wr_en=1, wr_addr={px[9:0],py[9:0]}, wr_data=colour.
  - Out of range: wr_en=0 for that slot, but the slot still consumes its cycle. Latency is therefore fixed at N=(2*BRUSH_R+1)^2 cycles.
  - After the last slot, return to IDLE. With no pending clear, paint_ready is high again in cycle T+N+1.
- CLEAR:
  - Sweeps y outer 0..V_RES-1 and x inner 0..H_RES-1, writing 0 with wr_en=1 every cycle. That is H_RES*V_RES = 307200 cycles.
  - First write is {0,0}. Last write is {639,479}.
  - clear_done pulses in the cycle after the last write, coincident with the return to IDLE.
  - clear_pend is cleared on entry to CLEAR.
- clear_req handling:
  - In IDLE: sets clear_pend; CLEAR is entered on the next edge.
  - During STAMP: latched into clear_pend; CLEAR runs immediately after the stamp completes. The stamp is never truncated.
  - During CLEAR: ignored, not re-queued.
  - Same edge as a paint handshake in IDLE: impossible by construction, because ready is already low once clear_pend is set. If both arrive in the same cycle with clear_pend=0, the paint is accepted and the clear is latched.
- Off-screen centres (cx>=H_RES or cy>=V_RES) are accepted and clip normally. A fully off-screen stamp produces N cycles with wr_en=0.
- busy = (state!=IDLE), registered alongside state.
- Between operations wr_en=0. wr_addr and wr_data hold their last values (don't-care).

Decomposition:
- Package canvas_pkg:
  - H_RES and V_RES constants.
  - typedef color_t = logic[COLOR_W-1:0].
  - typedef canvas_addr_t = logic[19:0].
  - enum ctrl_state_t {IDLE, STAMP, CLEAR}.
  - Function pack_addr(x,y).
- Sub-module raster_scan:
  - Two-level counter with start, per-axis min/max bounds, step enable, current (x,y) and last flag.
  - One instance is reused by STAMP (bounds -R..R) and CLEAR (bounds 0..H_RES-1 / 0..V_RES-1).

Test Plan:
- Centre stamp: reset, then paint (100,50) colour 1 -> 25 consecutive wr_en=1 cycles starting T+1. First addr {98,48}, last addr {102,52}, data 1. busy high for 25 cycles. paint_ready high at T+26.
- Corner clip: paint (0,0) colour 3 -> 25 cycles. wr_en=1 only for x,y in 0..2 (9 writes). The 16 negative-coordinate slots have wr_en=0.
- Full clear: one-cycle clear_req in IDLE -> 307200 writes of 0 in order {0,0},{1,0}..{639,479}. clear_done is a single pulse the next cycle. paint_ready is low throughout.
- Clear during stamp: clear_req at stamp cycle 5 -> all 25 stamp slots complete, then CLEAR begins the next cycle. A paint_valid held high is not accepted until after clear_done.
- Backpressure/priority: paint_valid held high with changing x during STAMP -> only the value present at the ready edge is latched. Mid-sweep clear_req during CLEAR is ignored (exactly one clear_done).
- Reset mid-CLEAR: Reset_n low at sweep cycle 1000 -> next edge wr_en=0, busy=0, state IDLE, no clear_done. After release, paint_ready=1 with clear_pend=0.

Source files
------------

// File: rtl/canvas_pkg.sv
// Shared types and constants for the paint-canvas write path.
// Canvas addresses are {x[9:0], y[9:0]}.
package canvas_pkg;

    localparam int H_RES   = 640;
    localparam int V_RES   = 480;
    localparam int BRUSH_R = 2;
    localparam int COLOR_W = 2;

    typedef logic [COLOR_W-1:0] color_t;
    typedef logic [19:0]        canvas_addr_t;

    typedef enum logic [1:0] {
        IDLE,
        STAMP,
        CLEAR
    } ctrl_state_t;

    function automatic canvas_addr_t pack_addr(
        input logic [9:0] x,
        input logic [9:0] y
    );
        return {x, y};
    endfunction

endpackage

// File: rtl/raster_scan.sv
// Two-level signed raster counter, x inner and y outer.
// nx/ny expose the position that becomes current after this edge.
module raster_scan #(
    parameter int W = 11
) (
    input  logic                CLK,
    input  logic                Reset_n,
    input  logic                start,
    input  logic                step,
    input  logic signed [W-1:0] x_min,
    input  logic signed [W-1:0] x_max,
    input  logic signed [W-1:0] y_min,
    input  logic signed [W-1:0] y_max,
    output logic signed [W-1:0] nx,
    output logic signed [W-1:0] ny,
    output logic                last
);

    localparam logic signed [W-1:0] ONE = 1;

    logic signed [W-1:0] x_q;
    logic signed [W-1:0] y_q;
    logic signed [W-1:0] xmin_q;
    logic signed [W-1:0] xmax_q;
    logic signed [W-1:0] ymax_q;
    logic                wrap;

    always_comb begin
        wrap = (x_q == xmax_q);
        last = wrap && (y_q == ymax_q);
        nx   = x_q;
        ny   = y_q;
        if (start) begin
            nx = x_min;
            ny = y_min;
        end else if (step) begin
            nx = wrap ? xmin_q : x_q + ONE;
            ny = wrap ? y_q + ONE : y_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (!Reset_n) begin
            x_q    <= '0;
            y_q    <= '0;
            xmin_q <= '0;
            xmax_q <= '0;
            ymax_q <= '0;
        end else begin
            x_q <= nx;
            y_q <= ny;
            if (start) begin
                xmin_q <= x_min;
                xmax_q <= x_max;
                ymax_q <= y_max;
            end
        end
    end

endmodule

// File: rtl/canvas_write_ctrl.sv
// Canvas RAM write-port owner: brush stamps and full-canvas clears,
// one pixel per cycle through a shared raster counter.
module canvas_write_ctrl
    import canvas_pkg::*;
#(
    parameter int H_RES   = canvas_pkg::H_RES,
    parameter int V_RES   = canvas_pkg::V_RES,
    parameter int BRUSH_R = canvas_pkg::BRUSH_R
) (
    input  logic         CLK,
    input  logic         Reset_n,
    input  logic         paint_valid,
    output logic         paint_ready,
    input  logic [9:0]   paint_x,
    input  logic [9:0]   paint_y,
    input  color_t       paint_color,
    input  logic         clear_req,
    output logic         wr_en,
    output canvas_addr_t wr_addr,
    output color_t       wr_data,
    output logic         busy,
    output logic         clear_done
);

    localparam int W = 11;
    typedef logic signed [W-1:0] coord_t;

    localparam coord_t POS_R = coord_t'(BRUSH_R);
    localparam coord_t NEG_R = -coord_t'(BRUSH_R);
    localparam coord_t H_LIM = coord_t'(H_RES);
    localparam coord_t V_LIM = coord_t'(V_RES);

    ctrl_state_t state_q, state_d;
    logic        clear_pend_q, clear_pend_d;
    logic [9:0]  cx_q, cy_q;
    color_t      col_q;

    logic        start, step, emit, use_in, sweep;
    logic        clear_done_d, last, in_range;
    coord_t      x_min, x_max, y_min, y_max;
    coord_t      nx, ny, px, py;
    logic [9:0]  cen_x, cen_y;
    color_t      col;

    assign paint_ready = (state_q == IDLE) && !clear_pend_q && Reset_n;

    always_comb begin
        state_d      = state_q;
        clear_pend_d = clear_pend_q;
        start        = 1'b0;
        step         = 1'b0;
        emit         = 1'b0;
        use_in       = 1'b0;
        clear_done_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (clear_pend_q) begin
                    state_d      = CLEAR;
                    clear_pend_d = 1'b0;
                    start        = 1'b1;
                    emit         = 1'b1;
                end else if (paint_valid && paint_ready) begin
                    state_d = STAMP;
                    start   = 1'b1;
                    emit    = 1'b1;
                    use_in  = 1'b1;
                    if (clear_req) clear_pend_d = 1'b1;
                end else if (clear_req) begin
                    clear_pend_d = 1'b1;
                end
            end
            STAMP: begin
                if (clear_req) clear_pend_d = 1'b1;
                if (!last) begin
                    step = 1'b1;
                    emit = 1'b1;
                end else if (clear_pend_q || clear_req) begin
                    // Chain straight into the sweep; no idle gap.
                    state_d      = CLEAR;
                    clear_pend_d = 1'b0;
                    start        = 1'b1;
                    emit         = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            CLEAR: begin
                if (!last) begin
                    step = 1'b1;
                    emit = 1'b1;
                end else begin
                    state_d      = IDLE;
                    clear_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sweep = (state_d == CLEAR);
        x_min = sweep ? coord_t'(0) : NEG_R;
        x_max = sweep ? H_LIM - coord_t'(1) : POS_R;
        y_min = sweep ? coord_t'(0) : NEG_R;
        y_max = sweep ? V_LIM - coord_t'(1) : POS_R;
        cen_x = sweep ? '0 : (use_in ? paint_x : cx_q);
        cen_y = sweep ? '0 : (use_in ? paint_y : cy_q);
        col   = sweep ? '0 : (use_in ? paint_color : col_q);
        px    = coord_t'({1'b0, cen_x}) + nx;
        py    = coord_t'({1'b0, cen_y}) + ny;
        in_range = !px[W-1] && (px < H_LIM) && !py[W-1] && (py < V_LIM);
    end

    raster_scan #(.W(W)) u_scan (
        .CLK     (CLK),
        .Reset_n (Reset_n),
        .start   (start),
        .step    (step),
        .x_min   (x_min),
        .x_max   (x_max),
        .y_min   (y_min),
        .y_max   (y_max),
        .nx      (nx),
        .ny      (ny),
        .last    (last)
    );

    always_ff @(posedge CLK) begin
        if (!Reset_n) begin
            state_q      <= IDLE;
            clear_pend_q <= 1'b0;
            cx_q         <= '0;
            cy_q         <= '0;
            col_q        <= '0;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            busy         <= 1'b0;
            clear_done   <= 1'b0;
        end else begin
            state_q      <= state_d;
            clear_pend_q <= clear_pend_d;
            busy         <= (state_d != IDLE);
            clear_done   <= clear_done_d;
            wr_en        <= emit && in_range;
            if (emit && in_range) begin
                wr_addr <= pack_addr(px[9:0], py[9:0]);
                wr_data <= col;
            end
            if (use_in) begin
                cx_q  <= paint_x;
                cy_q  <= paint_y;
                col_q <= paint_color;
            end
        end
    end

endmodule

// File: tb/tb_canvas_write_ctrl.sv
// Self-checking bench for canvas_write_ctrl on a reduced canvas so
// full clears stay short; expectations come from plain pixel arithmetic.
module tb_canvas_write_ctrl;

    localparam int H = 48;
    localparam int V = 32;
    localparam int R = 2;
    localparam int S = 2 * R + 1;
    localparam int N = S * S;

    logic        CLK = 1'b0;
    logic        Reset_n = 1'b0;
    logic        paint_valid = 1'b0;
    logic        paint_ready;
    logic [9:0]  paint_x = '0;
    logic [9:0]  paint_y = '0;
    logic [1:0]  paint_color = '0;
    logic        clear_req = 1'b0;
    logic        wr_en;
    logic [19:0] wr_addr;
    logic [1:0]  wr_data;
    logic        busy;
    logic        clear_done;

    int checks = 0;
    int errors = 0;

    canvas_write_ctrl #(
        .H_RES   (H),
        .V_RES   (V),
        .BRUSH_R (R)
    ) dut (
        .CLK         (CLK),
        .Reset_n     (Reset_n),
        .paint_valid (paint_valid),
        .paint_ready (paint_ready),
        .paint_x     (paint_x),
        .paint_y     (paint_y),
        .paint_color (paint_color),
        .clear_req   (clear_req),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .busy        (busy),
        .clear_done  (clear_done)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        paint_valid = 1'b1;
        repeat (3) tick();
        checks++;
        if ({wr_en, busy, clear_done, paint_ready} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 0000",
                     {wr_en, busy, clear_done, paint_ready});
        end
        checks++;
        if ({wr_addr, wr_data} !== 22'h0) begin
            errors++;
            $display("FAIL reset_addr_data: got %h expected 0",
                     {wr_addr, wr_data});
        end
        paint_valid = 1'b0;
        Reset_n = 1'b1;
        #1;
        checks++;
        if (paint_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b expected 1", paint_ready);
        end
        tick();
        checks++;
        if ({wr_en, busy, paint_ready} !== 3'b001) begin
            errors++;
            $display("FAIL reset_idle: got %b expected 001",
                     {wr_en, busy, paint_ready});
        end
    endtask

    // Stamp at (cx,cy); hold keeps paint_valid high with scrambled
    // coordinates; clr_at >= 0 pulses clear_req at that slot.
    task automatic test_stamp(input int cx, input int cy, input int col,
                              input bit hold, input int clr_at,
                              input string name);
        int px, py;
        bit en;
        checks++;
        if (paint_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready_before: got %b expected 1", name, paint_ready);
        end
        paint_valid = 1'b1;
        paint_x = 10'(cx);
        paint_y = 10'(cy);
        paint_color = 2'(col);
        tick();
        paint_valid = hold;
        for (int k = 0; k < N; k++) begin
            px = cx + (k % S) - R;
            py = cy + (k / S) - R;
            en = (px >= 0) && (px < H) && (py >= 0) && (py < V);
            checks++;
            if ({wr_en, busy, paint_ready, clear_done} !== {en, 3'b100}) begin
                errors++;
                $display("FAIL %s_slot%0d_flags: got %b expected %b", name, k,
                         {wr_en, busy, paint_ready, clear_done}, {en, 3'b100});
            end
            if (en) begin
                checks++;
                if ({wr_addr, wr_data} !== {20'(px * 1024 + py), 2'(col)}) begin
                    errors++;
                    $display("FAIL %s_slot%0d_write: got %h/%0d expected %h/%0d",
                             name, k, wr_addr, wr_data, 20'(px * 1024 + py), col);
                end
            end
            if (hold) begin
                paint_x = 10'($urandom_range(0, 1023));
                paint_y = 10'($urandom_range(0, 1023));
            end
            if (k == clr_at) clear_req = 1'b1;
            tick();
            clear_req = 1'b0;
        end
        if (clr_at < 0) begin
            checks++;
            if ({wr_en, busy, paint_ready} !== 3'b001) begin
                errors++;
                $display("FAIL %s_done: got %b expected 001", name,
                         {wr_en, busy, paint_ready});
            end
        end
    endtask

    // Current cycle must show the first clear write.
    task automatic run_sweep(input int mid_at, input string name);
        int idx;
        for (int y = 0; y < V; y++) begin
            for (int x = 0; x < H; x++) begin
                idx = y * H + x;
                checks++;
                if ({wr_en, busy, paint_ready, clear_done} !== 4'b1100) begin
                    errors++;
                    $display("FAIL %s_flags@%0d: got %b expected 1100", name, idx,
                             {wr_en, busy, paint_ready, clear_done});
                end
                checks++;
                if ({wr_addr, wr_data} !== {20'(x * 1024 + y), 2'b00}) begin
                    errors++;
                    $display("FAIL %s_write@%0d: got %h/%0d expected %h/0", name,
                             idx, wr_addr, wr_data, 20'(x * 1024 + y));
                end
                if (idx == mid_at) clear_req = 1'b1;
                tick();
                clear_req = 1'b0;
            end
        end
        checks++;
        if ({wr_en, busy, paint_ready, clear_done} !== 4'b0011) begin
            errors++;
            $display("FAIL %s_done: got %b expected 0011", name,
                     {wr_en, busy, paint_ready, clear_done});
        end
    endtask

    task automatic test_clear();
        paint_valid = 1'b0;
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        checks++;
        if ({wr_en, busy, paint_ready, clear_done} !== 4'b0000) begin
            errors++;
            $display("FAIL clear_pending: got %b expected 0000",
                     {wr_en, busy, paint_ready, clear_done});
        end
        tick();
        run_sweep(100, "clear");
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({wr_en, busy, paint_ready, clear_done} !== 4'b0010) begin
                errors++;
                $display("FAIL clear_after%0d: got %b expected 0010", i,
                         {wr_en, busy, paint_ready, clear_done});
            end
        end
    endtask

    task automatic test_clear_during_stamp();
        test_stamp(20, 15, 2, 1'b1, 5, "stamp_clr");
        run_sweep(-1, "chained_clear");
        test_stamp(30, 20, 1, 1'b0, -1, "after_clear");
    endtask

    task automatic test_back_to_back();
        test_stamp(5, 6, 1, 1'b1, -1, "b2b_a");
        test_stamp(H - 2, 3, 2, 1'b1, -1, "b2b_b");
        test_stamp(7, V - 1, 3, 1'b0, -1, "b2b_c");
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            test_stamp(int'($urandom_range(0, H + 3)),
                       int'($urandom_range(0, V + 3)),
                       int'($urandom_range(0, 3)), 1'b0, -1, "rand");
        end
    endtask

    task automatic test_reset_mid_clear();
        paint_valid = 1'b0;
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        tick();
        repeat (1000) tick();
        checks++;
        if ({wr_en, wr_addr} !== {1'b1, 20'((1000 % H) * 1024 + 1000 / H)}) begin
            errors++;
            $display("FAIL midclear_write: got %b/%h expected 1/%h", wr_en,
                     wr_addr, 20'((1000 % H) * 1024 + 1000 / H));
        end
        Reset_n = 1'b0;
        tick();
        checks++;
        if ({wr_en, busy, paint_ready, clear_done} !== 4'b0000) begin
            errors++;
            $display("FAIL midclear_reset: got %b expected 0000",
                     {wr_en, busy, paint_ready, clear_done});
        end
        Reset_n = 1'b1;
        #1;
        checks++;
        if (paint_ready !== 1'b1) begin
            errors++;
            $display("FAIL midclear_ready: got %b expected 1", paint_ready);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({wr_en, busy, paint_ready, clear_done} !== 4'b0010) begin
                errors++;
                $display("FAIL midclear_idle%0d: got %b expected 0010", i,
                         {wr_en, busy, paint_ready, clear_done});
            end
        end
    endtask

    initial begin
        test_reset();
        test_stamp(10, 10, 1, 1'b0, -1, "centre");
        test_stamp(0, 0, 3, 1'b0, -1, "corner");
        test_stamp(H - 1, V - 1, 2, 1'b0, -1, "far_corner");
        test_stamp(H + 5, V + 5, 1, 1'b0, -1, "offscreen");
        test_random();
        test_back_to_back();
        test_clear();
        test_clear_during_stamp();
        test_reset_mid_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
